// File: rtl/leon_mem_arbiter.sv
// Shares one memory port between the instruction-fetch and data sides. Contention
// alternates priority, and a per-transaction wait counter aborts a stalled access.
module leon_mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    input  logic        d_req_i,
    input  logic        d_write_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        i_hold_o,
    output logic        i_done_o,
    output logic [31:0] i_data_o,
    output logic        i_exception_o,
    output logic        d_hold_o,
    output logic        d_done_o,
    output logic [31:0] d_data_o,
    output logic        d_mexc_o,
    output logic        d_werr_o,
    output logic        m_req_o,
    output logic        m_wr_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    input  logic [31:0] m_rdata_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [9:0] TimeoutC = 10'(TIMEOUT);

    state_e      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic        lastData_q, lastData_d;
    logic        ownerData_q, ownerData_d;
    logic        m_req_q, m_req_d;
    logic        m_wr_q, m_wr_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic        i_hold_q, i_hold_d;
    logic        d_hold_q, d_hold_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;
    logic [31:0] i_data_q, i_data_d;
    logic [31:0] d_data_q, d_data_d;
    logic        i_exc_q, i_exc_d;
    logic        d_mexc_q, d_mexc_d;
    logic        d_werr_q, d_werr_d;

    logic        grantData;
    logic        finish;
    logic        finErr;
    logic [31:0] finData;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        lastData_d  = lastData_q;
        ownerData_d = ownerData_q;
        m_req_d     = m_req_q;
        m_wr_d      = m_wr_q;
        m_addr_d    = m_addr_q;
        m_wdata_d   = m_wdata_q;
        i_hold_d    = i_hold_q;
        d_hold_d    = d_hold_q;
        i_data_d    = i_data_q;
        d_data_d    = d_data_q;
        i_done_d    = 1'b0;
        d_done_d    = 1'b0;
        i_exc_d     = 1'b0;
        d_mexc_d    = 1'b0;
        d_werr_d    = 1'b0;
        grantData   = 1'b0;
        finish      = 1'b0;
        finErr      = 1'b0;
        finData     = '0;

        case (state_q)
            IDLE: begin
                if (i_req_i || d_req_i) begin
                    // Priority only flips on contention; a lone request leaves it alone.
                    grantData   = d_req_i && (!i_req_i || !lastData_q);
                    if (i_req_i && d_req_i) begin
                        lastData_d = grantData;
                    end
                    ownerData_d = grantData;
                    m_req_d     = 1'b1;
                    cnt_d       = '0;
                    state_d     = BUSY;
                    if (grantData) begin
                        m_wr_d    = d_write_i;
                        m_addr_d  = d_addr_i;
                        m_wdata_d = d_wdata_i;
                        d_hold_d  = 1'b0;
                    end else begin
                        m_wr_d    = 1'b0;
                        m_addr_d  = i_addr_i;
                        m_wdata_d = '0;
                        i_hold_d  = 1'b0;
                    end
                end
            end
            BUSY: begin
                if (m_ack_i) begin
                    finish  = 1'b1;
                    finErr  = m_err_i;
                    finData = m_rdata_i;
                end else if (cnt_q + 10'd1 == TimeoutC) begin
                    finish  = 1'b1;
                    finErr  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
                if (finish) begin
                    m_req_d  = 1'b0;
                    i_hold_d = 1'b1;
                    d_hold_d = 1'b1;
                    state_d  = DONE;
                    if (ownerData_q) begin
                        d_done_d = 1'b1;
                        if (m_wr_q) begin
                            d_data_d = '0;
                            d_werr_d = finErr;
                        end else begin
                            d_data_d = finData;
                            d_mexc_d = finErr;
                        end
                    end else begin
                        i_done_d = 1'b1;
                        i_data_d = finData;
                        i_exc_d  = finErr;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lastData_q  <= 1'b1;
            ownerData_q <= 1'b0;
            m_req_q     <= 1'b0;
            m_wr_q      <= 1'b0;
            m_addr_q    <= '0;
            m_wdata_q   <= '0;
            i_hold_q    <= 1'b1;
            d_hold_q    <= 1'b1;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_data_q    <= '0;
            d_data_q    <= '0;
            i_exc_q     <= 1'b0;
            d_mexc_q    <= 1'b0;
            d_werr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lastData_q  <= lastData_d;
            ownerData_q <= ownerData_d;
            m_req_q     <= m_req_d;
            m_wr_q      <= m_wr_d;
            m_addr_q    <= m_addr_d;
            m_wdata_q   <= m_wdata_d;
            i_hold_q    <= i_hold_d;
            d_hold_q    <= d_hold_d;
            i_done_q    <= i_done_d;
            d_done_q    <= d_done_d;
            i_data_q    <= i_data_d;
            d_data_q    <= d_data_d;
            i_exc_q     <= i_exc_d;
            d_mexc_q    <= d_mexc_d;
            d_werr_q    <= d_werr_d;
        end
    end

    assign m_req_o       = m_req_q;
    assign m_wr_o        = m_wr_q;
    assign m_addr_o      = m_addr_q;
    assign m_wdata_o     = m_wdata_q;
    assign i_hold_o      = i_hold_q;
    assign d_hold_o      = d_hold_q;
    assign i_done_o      = i_done_q;
    assign d_done_o      = d_done_q;
    assign i_data_o      = i_data_q;
    assign d_data_o      = d_data_q;
    assign i_exception_o = i_exc_q;
    assign d_mexc_o      = d_mexc_q;
    assign d_werr_o      = d_werr_q;

endmodule

// File: tb/tb_leon_mem_arbiter.sv
// Scoreboard bench for leon_mem_arbiter: requesters and a latency-programmable memory
// push expectations; a monitor pops them whenever a done pulse appears.
module tb_leon_mem_arbiter;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        iReq = 1'b0;
    logic [31:0] iAddr = '0;
    logic        dReq = 1'b0;
    logic        dWrite = 1'b0;
    logic [31:0] dAddr = '0;
    logic [31:0] dWdata = '0;
    logic        mAck = 1'b0;
    logic        mErr = 1'b0;
    logic [31:0] mRdata = '0;
    logic        i_hold_o, i_done_o, i_exception_o;
    logic        d_hold_o, d_done_o, d_mexc_o, d_werr_o;
    logic [31:0] i_data_o, d_data_o;
    logic        m_req_o, m_wr_o;
    logic [31:0] m_addr_o, m_wdata_o;

    always #5 clk = ~clk;

    leon_mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_i(iReq), .i_addr_i(iAddr),
        .d_req_i(dReq), .d_write_i(dWrite), .d_addr_i(dAddr), .d_wdata_i(dWdata),
        .i_hold_o(i_hold_o), .i_done_o(i_done_o), .i_data_o(i_data_o),
        .i_exception_o(i_exception_o),
        .d_hold_o(d_hold_o), .d_done_o(d_done_o), .d_data_o(d_data_o),
        .d_mexc_o(d_mexc_o), .d_werr_o(d_werr_o),
        .m_req_o(m_req_o), .m_wr_o(m_wr_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
        .m_ack_i(mAck), .m_err_i(mErr), .m_rdata_i(mRdata)
    );

    typedef struct {
        int          lat;
        bit          err;
        logic [31:0] rdata;
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
    } plan_t;

    typedef struct {
        bit          isData;
        logic [31:0] data;
        bit          exc;
        bit          mexc;
        bit          werr;
        int          cycles;
    } exp_t;

    plan_t       planQ[$];
    exp_t        expQ[$];
    int          nChecks = 0;
    int          nFails = 0;
    bit          modelLastData = 1'b1;
    logic [31:0] modelIData = '0;
    logic [31:0] modelDData = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // What the requester should see, derived from the memory's planned behaviour.
    function automatic exp_t predict(input bit isData, input plan_t p);
        exp_t e;
        bit   timedOut;
        bit   errFlag;
        timedOut = (p.lat > TIMEOUT);
        errFlag  = timedOut || p.err;
        e.isData = isData;
        e.cycles = timedOut ? TIMEOUT : p.lat;
        e.data   = (timedOut || (isData && p.wr)) ? 32'h0 : p.rdata;
        e.exc    = !isData && errFlag;
        e.mexc   = isData && !p.wr && errFlag;
        e.werr   = isData && p.wr && errFlag;
        return e;
    endfunction

    // Memory: acks in the lat-th cycle of m_req, junk on the ack lines otherwise.
    initial begin : memModel
        plan_t cur;
        int    cyc;
        bit    inFlight;
        cyc = 0;
        inFlight = 1'b0;
        cur.lat = 1000; cur.err = 1'b0; cur.rdata = '0;
        cur.addr = '0; cur.wr = 1'b0; cur.wdata = '0;
        forever begin
            @(negedge clk);
            mAck   = 1'($urandom_range(0, 1));
            mErr   = 1'($urandom_range(0, 1));
            mRdata = $urandom();
            if (m_req_o) begin
                if (!inFlight) begin
                    if (planQ.size() == 0) begin
                        nChecks++;
                        nFails++;
                        $display("[TB] FAIL unplanned m_req: got 1, expected 0");
                        cur.lat = 1000;
                    end else begin
                        cur = planQ.pop_front();
                    end
                    inFlight = 1'b1;
                    cyc = 1;
                end else begin
                    cyc++;
                end
                mAck = 1'b0;
                mErr = 1'b0;
                checkOutput("m_addr", m_addr_o, cur.addr);
                checkOutput("m_wr", {31'b0, m_wr_o}, {31'b0, cur.wr});
                if (cur.wr) checkOutput("m_wdata", m_wdata_o, cur.wdata);
                if (cyc == cur.lat) begin
                    mAck   = 1'b1;
                    mErr   = cur.err;
                    mRdata = cur.rdata;
                end
            end else begin
                inFlight = 1'b0;
            end
        end
    end

    initial begin : monitor
        int   iLow;
        int   dLow;
        exp_t e;
        iLow = 0;
        dLow = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                iLow = 0;
                dLow = 0;
                modelIData = '0;
                modelDData = '0;
            end else begin
                if (!i_hold_o) iLow++;
                if (!d_hold_o) dLow++;
                if (!i_done_o) checkOutput("i_exception idle", {31'b0, i_exception_o}, 32'h0);
                if (!d_done_o) checkOutput("d errors idle", {30'b0, d_mexc_o, d_werr_o}, 32'h0);
                if (i_done_o) begin
                    if (expQ.size() == 0 || expQ[0].isData) begin
                        nChecks++;
                        nFails++;
                        $display("[TB] FAIL unexpected i_done: got 1, expected 0");
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("i_data", i_data_o, e.data);
                        checkOutput("i_exception", {31'b0, i_exception_o}, {31'b0, e.exc});
                        checkOutput("i_hold low cycles", 32'(iLow), 32'(e.cycles));
                        checkOutput("d_data held", d_data_o, modelDData);
                        modelIData = e.data;
                    end
                    iLow = 0;
                end
                if (d_done_o) begin
                    if (expQ.size() == 0 || !expQ[0].isData) begin
                        nChecks++;
                        nFails++;
                        $display("[TB] FAIL unexpected d_done: got 1, expected 0");
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("d_data", d_data_o, e.data);
                        checkOutput("d_mexc", {31'b0, d_mexc_o}, {31'b0, e.mexc});
                        checkOutput("d_werr", {31'b0, d_werr_o}, {31'b0, e.werr});
                        checkOutput("d_hold low cycles", 32'(dLow), 32'(e.cycles));
                        checkOutput("i_data held", i_data_o, modelIData);
                        modelDData = e.data;
                    end
                    dLow = 0;
                end
            end
        end
    end

    // mode 0 = fetch only, 1 = data only, 2 = both contend.
    task automatic applyStimulus(input int mode, input logic [31:0] iA, input logic [31:0] dA,
                                 input bit dW, input logic [31:0] dWd,
                                 input int latF, input bit errF, input logic [31:0] rdF,
                                 input int latD, input bit errD, input logic [31:0] rdD);
        plan_t pF, pD;
        bit    dataFirst;
        int    budget;
        pF.lat = latF; pF.err = errF; pF.rdata = rdF; pF.addr = iA; pF.wr = 1'b0; pF.wdata = '0;
        pD.lat = latD; pD.err = errD; pD.rdata = rdD; pD.addr = dA; pD.wr = dW;   pD.wdata = dWd;
        if (mode == 0)      dataFirst = 1'b0;
        else if (mode == 1) dataFirst = 1'b1;
        else begin
            dataFirst = !modelLastData;
            modelLastData = dataFirst;
        end
        if (dataFirst) begin
            planQ.push_back(pD);
            expQ.push_back(predict(1'b1, pD));
            if (mode == 2) begin
                planQ.push_back(pF);
                expQ.push_back(predict(1'b0, pF));
            end
        end else begin
            planQ.push_back(pF);
            expQ.push_back(predict(1'b0, pF));
            if (mode == 2) begin
                planQ.push_back(pD);
                expQ.push_back(predict(1'b1, pD));
            end
        end
        @(negedge clk);
        iReq   = (mode != 1);
        iAddr  = iA;
        dReq   = (mode != 0);
        dAddr  = dA;
        dWrite = dW;
        dWdata = dWd;
        budget = 0;
        while ((iReq || dReq) && budget < 100) begin
            @(negedge clk);
            budget++;
            if (!i_hold_o) iAddr = $urandom();
            if (!d_hold_o) begin
                dAddr  = $urandom();
                dWdata = $urandom();
                dWrite = 1'($urandom_range(0, 1));
            end
            if (i_done_o) iReq = 1'b0;
            if (d_done_o) dReq = 1'b0;
        end
        if (iReq || dReq) begin
            nChecks++;
            nFails++;
            $display("[TB] FAIL completion wait: got no done in %0d cycles, expected done", budget);
            iReq = 1'b0;
            dReq = 1'b0;
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " m_req"}, {31'b0, m_req_o}, 32'h0);
        checkOutput({tag, " m_wr"}, {31'b0, m_wr_o}, 32'h0);
        checkOutput({tag, " m_addr"}, m_addr_o, 32'h0);
        checkOutput({tag, " m_wdata"}, m_wdata_o, 32'h0);
        checkOutput({tag, " holds"}, {30'b0, i_hold_o, d_hold_o}, 32'h3);
        checkOutput({tag, " done/err"},
                    {27'b0, i_done_o, d_done_o, i_exception_o, d_mexc_o, d_werr_o}, 32'h0);
        checkOutput({tag, " i_data"}, i_data_o, 32'h0);
        checkOutput({tag, " d_data"}, d_data_o, 32'h0);
    endtask

    task automatic resetMidBusy();
        plan_t p;
        p.lat = 1000; p.err = 1'b0; p.rdata = '0; p.addr = 32'h0000_1234; p.wr = 1'b0; p.wdata = '0;
        planQ.push_back(p);
        @(negedge clk);
        iReq  = 1'b1;
        iAddr = 32'h0000_1234;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1 checkResetState("mid-busy reset");
        iReq = 1'b0;
        modelLastData = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int mode;
        repeat (2) @(negedge clk);
        checkResetState("power-on reset");
        rst_n = 1'b1;

        applyStimulus(0, 32'h4000_0000, 32'h0, 1'b0, 32'h0, 3, 1'b0, 32'h8E00_C002, 1, 1'b0, 32'h0);
        applyStimulus(2, 32'h4000_0010, 32'h2000_0000, 1'b0, 32'h0,
                      2, 1'b0, 32'h1111_1111, 1, 1'b0, 32'h2222_2222);
        applyStimulus(2, 32'h4000_0020, 32'h2000_0004, 1'b0, 32'h0,
                      1, 1'b0, 32'h3333_3333, 2, 1'b0, 32'h4444_4444);
        applyStimulus(1, 32'h0, 32'h2000_0008, 1'b1, 32'h13, 2, 1'b0, 32'h0, 2, 1'b1, 32'hDEAD_BEEF);
        applyStimulus(1, 32'h0, 32'h2000_000C, 1'b0, 32'h0, 1, 1'b0, 32'h0, 1000, 1'b0, 32'h0);
        applyStimulus(1, 32'h0, 32'h2000_0010, 1'b0, 32'h0, 1, 1'b0, 32'h0, TIMEOUT, 1'b0, 32'h5555_AAAA);
        applyStimulus(0, 32'h4000_0030, 32'h0, 1'b0, 32'h0, 1000, 1'b0, 32'h0, 1, 1'b0, 32'h0);

        for (int n = 0; n < 40; n++) begin
            mode = int'($urandom_range(0, 2));
            applyStimulus(mode, $urandom(), $urandom(), 1'($urandom_range(0, 1)), $urandom(),
                          int'($urandom_range(1, TIMEOUT + 2)), 1'($urandom_range(0, 1)), $urandom(),
                          int'($urandom_range(1, TIMEOUT + 2)), 1'($urandom_range(0, 1)), $urandom());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        resetMidBusy();
        applyStimulus(0, 32'h4000_0040, 32'h0, 1'b0, 32'h0, 2, 1'b0, 32'hCAFE_F00D, 1, 1'b0, 32'h0);
        applyStimulus(2, 32'h4000_0050, 32'h2000_0020, 1'b1, 32'h77,
                      1, 1'b0, 32'h0BAD_0001, 3, 1'b0, 32'h0);

        repeat (5) @(negedge clk);
        checkOutput("pending expectations", 32'(expQ.size()), 32'h0);
        checkOutput("unused memory plans", 32'(planQ.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/leon_mem_arbiter.md
LEON_MEM_ARBITER -- requirements
Module: leon_mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles waited for m_ack before abort; range 1..1023.
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 i_req  in  1  instruction-fetch request, level.
REQ-005 i_addr  in  32  fetch address.
REQ-006 d_req  in  1  data-access request, level.
REQ-007 d_write  in  1  1 = store, 0 = load.
REQ-008 d_addr  in  32  data address.
REQ-009 d_wdata  in  32  store data.
REQ-010 i_hold  out  1  active-low stall to fetch side; 1 = run.
REQ-011 i_done  out  1  one-cycle fetch completion pulse.
REQ-012 i_data  out  32  fetched instruction, valid with i_done.
REQ-013 i_exception  out  1  fetch error, valid with i_done.
REQ-014 d_hold  out  1  active-low stall to data side; 1 = run.
REQ-015 d_done  out  1  one-cycle data completion pulse.
REQ-016 d_data  out  32  load data, valid with d_done.
REQ-017 d_mexc  out  1  load error/timeout, valid with d_done.
REQ-018 d_werr  out  1  store error/timeout, valid with d_done.
REQ-019 m_req, m_wr  out  1 each  shared memory request / write strobe.
REQ-020 m_addr, m_wdata  out  32 each  memory address / write data.
REQ-021 m_ack, m_err  in  1 each  memory completion / error, sampled only while m_req=1.
REQ-022 m_rdata  in  32  memory read data, valid with m_ack.

Function
REQ-023 FSM states: IDLE, BUSY, DONE; one transaction in flight at a time.
REQ-024 IDLE: with either req high, latch winner's address/write/data into m_* regs, assert m_req next cycle, move to BUSY.
REQ-025 Single request is granted; both high -> grant the side not granted last (last_grant reg); fetch wins the first contention after reset.
REQ-026 Grant cycle N: m_req=1 and winner's hold=0 from N+1; loser's hold stays 1 until it is itself granted.
REQ-027 Fetch grant: m_wr=0, m_addr=i_addr; data grant: m_wr=d_write, m_addr=d_addr, m_wdata=d_wdata.
REQ-028 BUSY: m_ack in cycle M -> m_req=0, hold=1, done=1 and data register = m_rdata (0 for stores) at M+1; state DONE.
REQ-029 m_err with m_ack: fetch -> i_exception=1; load -> d_mexc=1; store -> d_werr=1; data still captured.
REQ-030 Wait counter: cleared on grant, +1 each BUSY cycle without m_ack; reaching TIMEOUT -> abort: m_req=0, done=1, data=0, error flag per REQ-029, state DONE.
REQ-031 m_ack in the same cycle the counter reaches TIMEOUT: ack wins, normal completion.
REQ-032 DONE lasts exactly one cycle, then IDLE; done, error flags drop to 0; data outputs hold last value.
REQ-033 Requester deasserts req on seeing done; req still high in IDLE is a new request (min 3-cycle spacing).
REQ-034 Request changes while not granted or while BUSY are ignored; m_* regs stable through BUSY.
REQ-035 m_ack/m_err outside BUSY ignored.

Reset
REQ-036 rst=0, any cycle including mid-transaction: immediately m_req=0, m_wr=0, m_addr=m_wdata=0, i_hold=d_hold=1, all done/error=0, i_data=d_data=0, counter=0, last_grant=data, state IDLE.
REQ-037 No in-flight transaction resumes after rst returns to 1.

Verification
REQ-038 i_req=1, i_addr=0x40000000, m_ack 3 cycles after m_req, m_rdata=0x8E00C002 -> i_hold low 3 cycles, i_done pulse, i_data=0x8E00C002, i_exception=0.
REQ-039 i_req, d_req both high in IDLE after reset -> fetch served first, then data; next contention -> data served first.
REQ-040 d_req, d_write=1, d_wdata=0x13, m_ack with m_err=1 -> m_wr=1, m_wdata=0x13, d_done=1, d_werr=1, d_mexc=0.
REQ-041 TIMEOUT=4, load, m_ack never -> m_req high 4 cycles, then d_done=1, d_mexc=1, d_data=0; m_ack in the 4th cycle -> normal completion.
REQ-042 rst=0 during BUSY -> m_req and all done flags 0 in the same cycle, holds 1; after release, new i_req completes normally.
